// File: rtl/srq_sched.sv
// srq_sched: round-robin scheduler that feeds NUM_REQ requesters into an
// external shared request queue (SRQ) and passes its tail straight to a
// downstream consumer. Tracks its own occupancy, supports drain and flush.
// Optional feature: define SRQ_SCHED_ERR_EN to build the sticky misuse checker.
module srq_sched #(
  parameter int WIDTH   = 1024,
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 4,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int OCW    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     srq_push,
  output logic [WIDTH+IDW-1:0]     srq_data_in,
  input  logic                     srq_full,
  input  logic                     srq_empty,
  input  logic                     srq_out_valid,
  input  logic [WIDTH+IDW-1:0]     srq_data_out,
  output logic                     srq_pop,
  input  logic                     srq_error_flag,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic [IDW-1:0]           out_id,
  input  logic                     out_ready,
  output logic [OCW-1:0]           occupancy,
  output logic                     busy,
  output logic                     flush_done,
  output logic                     err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_t;

  state_t           r_state, w_nxt;
  logic [IDW-1:0]   r_rr;
  logic [OCW-1:0]   r_occ;
  logic             w_can_push, w_act, w_found;
  logic [IDW-1:0]   w_gid;
  logic [WIDTH-1:0] w_pay;
  int               w_idx;

  assign w_act      = (r_state == RUN) || (r_state == DRAIN);
  assign w_can_push = (r_state == RUN) && (r_occ < OCW'(DEPTH)) && !srq_full;

  // round-robin pick: first valid requester at or after rr, wrapping
  always_comb begin
    req_ready = '0;
    w_found   = 1'b0;
    w_gid     = '0;
    w_pay     = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr) + k) % NUM_REQ;
      if (w_can_push && !w_found && req_valid[w_idx]) begin
        w_found          = 1'b1;
        req_ready[w_idx] = 1'b1;
        w_gid            = IDW'(w_idx);
        w_pay            = req_data[w_idx*WIDTH +: WIDTH];
      end
    end
  end

  assign srq_push    = w_found;
  assign srq_data_in = w_found ? {w_gid, w_pay} : '0;

  // zero-latency tail pass-through; flush discards one entry per cycle
  assign out_valid  = w_act && srq_out_valid;
  assign out_data   = w_act ? srq_data_out[WIDTH-1:0] : '0;
  assign out_id     = w_act ? srq_data_out[WIDTH+IDW-1:WIDTH] : '0;
  assign srq_pop    = (out_valid && out_ready) || ((r_state == FLUSH) && srq_out_valid);
  assign occupancy  = r_occ;
  assign busy       = (r_state != IDLE);
  assign flush_done = (r_state == FLUSH) && (r_occ == '0);

  // next state: flush wins everywhere except inside FLUSH itself
  always_comb begin
    w_nxt = r_state;
    if (flush && r_state != FLUSH) w_nxt = FLUSH;
    else begin
      case (r_state)
        IDLE:  if (en) w_nxt = RUN;
        RUN:   if (!en) w_nxt = DRAIN;
        DRAIN: if (en) w_nxt = RUN;
               else if (r_occ == '0) w_nxt = IDLE;
        FLUSH: if (r_occ == '0) w_nxt = IDLE;
        default: w_nxt = IDLE;
      endcase
    end
  end

  // state, rr pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rr    <= '0;
      r_occ   <= '0;
    end else begin
      r_state <= w_nxt;
      if (srq_push)
        r_rr <= (int'(w_gid) == NUM_REQ - 1) ? '0 : w_gid + 1'b1;
      if (srq_push && !srq_pop)
        r_occ <= r_occ + 1'b1;
      else if (srq_pop && !srq_push && r_occ != '0)
        r_occ <= r_occ - 1'b1;
    end
  end

`ifdef SRQ_SCHED_ERR_EN
  logic r_err;

  // sticky misuse detector, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_err <= 1'b0;
    else if (srq_error_flag || (srq_push && srq_full) ||
             (srq_pop && r_occ == '0) || (srq_empty && r_occ > OCW'(1)))
      r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{srq_empty, srq_error_flag};
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_srq_sched.sv
// Directed bench for srq_sched with a small behavioural SRQ model attached.
module tb_srq_sched;
  localparam int W = 8, NR = 4, D = 4, IDW = 2, OCW = 3;

  logic              clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0;
  logic [NR-1:0]     req_valid = '0, req_ready;
  logic [NR*W-1:0]   req_data;
  logic              srq_push, srq_pop, srq_full, srq_empty, srq_out_valid;
  logic [W+IDW-1:0]  srq_data_in, srq_data_out;
  logic              srq_error_flag = 1'b0;
  logic              out_valid, out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [IDW-1:0]    out_id;
  logic [OCW-1:0]    occupancy;
  logic              busy, flush_done, err;

  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  srq_sched #(.WIDTH(W), .NUM_REQ(NR), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .srq_push(srq_push), .srq_data_in(srq_data_in), .srq_full(srq_full),
    .srq_empty(srq_empty), .srq_out_valid(srq_out_valid),
    .srq_data_out(srq_data_out), .srq_pop(srq_pop),
    .srq_error_flag(srq_error_flag), .out_valid(out_valid),
    .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .occupancy(occupancy), .busy(busy), .flush_done(flush_done), .err(err)
  );

  // behavioural SRQ: 4-entry FIFO reset by the same rst
  logic [W+IDW-1:0] mem [D];
  logic [1:0]       hd, tl;
  logic [2:0]       cnt;
  assign srq_full      = (cnt == 3'(D));
  assign srq_empty     = (cnt == 3'd0);
  assign srq_out_valid = (cnt != 3'd0);
  assign srq_data_out  = mem[hd];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd <= '0; tl <= '0; cnt <= '0;
      for (int i = 0; i < D; i++) mem[i] <= '0;
    end else begin
      if (srq_push && cnt != 3'(D)) begin mem[tl] <= srq_data_in; tl <= tl + 2'd1; end
      if (srq_pop && cnt != 3'd0) hd <= hd + 2'd1;
      cnt <= cnt + 3'((srq_push && cnt != 3'(D)) ? 1 : 0) - 3'((srq_pop && cnt != 3'd0) ? 1 : 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  int n, pops, fd;
  logic [IDW-1:0] exp_ids [3];

  initial begin
    for (int i = 0; i < NR; i++) req_data[i*W +: W] = 8'h10 + 8'(i);
    exp_ids[0] = 2'd2; exp_ids[1] = 2'd3; exp_ids[2] = 2'd0;

    // reset values
    @(posedge clk); @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_outv", out_valid, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_err", err, 0);
    chk("rst_push", srq_push, 0);

    // fill: grants 0,1,2,3 then none
    tick(); rst = 1'b1; en = 1'b1; req_valid = 4'hF; #1;
    chk("idle_ready", req_ready, 0);
    tick();
    for (int g = 0; g < 4; g++) begin
      chk("fill_grant", req_ready, 32'(1 << g));
      chk("fill_din", srq_data_in, {30'(g), 8'h10 + 8'(g)} & 32'h3FF);
      tick();
    end
    chk("full_ready", req_ready, 0);
    chk("full_occ", occupancy, 4);
    chk("full_outv", out_valid, 1);
    chk("full_outid", out_id, 0);
    chk("full_outd", out_data, 8'h10);

    // full queue, pop then refill one per freed slot
    out_ready = 1'b1; req_valid = 4'b0001; #1;
    chk("fullpop_pop", srq_pop, 1);
    chk("fullpop_ready", req_ready, 0);
    tick();
    chk("refill_occ", occupancy, 3);
    chk("refill_grant", req_ready, 4'b0001);
    chk("refill_outid", out_id, 1);
    chk("refill_outd", out_data, 8'h11);
    tick();
    chk("steady_occ", occupancy, 3);

    // drain three entries with en low
    req_valid = '0; out_ready = 1'b0; en = 1'b0; #1;
    chk("pre_drain_id", out_id, 2);
    tick();
    chk("drain_busy", busy, 1);
    chk("drain_occ", occupancy, 3);
    out_ready = 1'b1; n = 0; #1;
    for (int c = 0; c < 10 && busy; c++) begin
      if (out_valid && n < 3) begin chk("drain_id", out_id, exp_ids[n]); n++; end
      tick();
    end
    chk("drain_count", n, 3);
    chk("drain_idle", busy, 0);
    chk("drain_occ0", occupancy, 0);

    // single push from req 2 with payload A5
    out_ready = 1'b0; en = 1'b1; req_valid = 4'b0100; req_data[2*W +: W] = 8'hA5;
    tick(); #1;
    chk("a5_grant", req_ready, 4'b0100);
    chk("a5_din", srq_data_in, 10'h2A5);
    tick(); req_valid = '0; #1;
    chk("a5_outv", out_valid, 1);
    chk("a5_outd", out_data, 8'hA5);
    chk("a5_outid", out_id, 2);
    chk("a5_occ", occupancy, 1);

    // fill to 4 then flush
    req_valid = 4'hF;
    for (int c = 0; c < 10 && occupancy != 3'd4; c++) tick();
    chk("fl_occ4", occupancy, 4);
    req_valid = '0; en = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0; #1;
    chk("fl_outv", out_valid, 0);
    chk("fl_ready", req_ready, 0);
    chk("fl_pop", srq_pop, 1);
    chk("fl_busy", busy, 1);
    pops = 0; fd = 0;
    for (int c = 0; c < 10 && busy; c++) begin
      if (srq_pop) pops++;
      if (flush_done) fd++;
      tick();
    end
    chk("fl_pops", pops, 4);
    chk("fl_done_pulses", fd, 1);
    chk("fl_occ0", occupancy, 0);
    chk("fl_idle", busy, 0);

    // flush with empty queue: one FLUSH cycle with flush_done
    flush = 1'b1; tick(); flush = 1'b0; #1;
    chk("fl0_done", flush_done, 1);
    chk("fl0_busy", busy, 1);
    tick();
    chk("fl0_done_low", flush_done, 0);
    chk("fl0_idle", busy, 0);

    // error flag pulse
    srq_error_flag = 1'b1; tick(); srq_error_flag = 1'b0; tick();
`ifdef SRQ_SCHED_ERR_EN
    chk("err_sticky", err, 1);
`else
    chk("err_off", err, 0);
`endif
    rst = 1'b0; #1;
    chk("err_rst", err, 0);
    chk("rst2_occ", occupancy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
